mem_arbiter: RTL and testbench

- Arbitrates the single-ported RAM between the instruction-fetch path and the data-memory path of the MIPS core.
- Sits between the datapath (imemREN/dREN/dWEN requests from control_unit_if-driven logic) and the RAM.
- Data accesses take priority. A starvation counter guarantees instruction fetch progress.
- A halt input drains the in-flight access and then freezes the arbiter.

---
 rtl/mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port RAM arbiter for fetch/data paths with starvation guard and halt drain
// Optional statistics counters (icount, dcount, stall_count) are enabled by defining MEM_ARB_STATS_EN.
module mem_arbiter #(
    parameter int WORD_W     = 32,
    parameter int STARVE_MAX = 4
`ifdef MEM_ARB_STATS_EN
    ,
    parameter int CNT_W      = 16
`endif
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              halt,
    input  logic              iREN,
    input  logic [WORD_W-1:0] iaddr,
    output logic              iwait,
    output logic [WORD_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [WORD_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    output logic              dwait,
    output logic [WORD_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [WORD_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic              ram_ack,
    output logic              halted
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0]  icount,
    output logic [CNT_W-1:0]  dcount,
    output logic [CNT_W-1:0]  stall_count
`endif
);

    localparam int SC_W = $clog2(STARVE_MAX + 1);
    localparam logic [SC_W-1:0] SC_MAX = SC_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [SC_W-1:0] r_starve_cnt;
    logic            w_dreq;
    logic            w_idone;
    logic            w_ddone;

    assign w_dreq  = dREN | dWEN;
    assign w_idone = (r_state == IGRANT) & ram_ack & iREN;
    assign w_ddone = (r_state == DGRANT) & ram_ack & w_dreq;

    assign iwait  = iREN & ~((r_state == IGRANT) & ram_ack);
    assign dwait  = w_dreq & ~((r_state == DGRANT) & ram_ack);
    assign iload  = ((r_state == IGRANT) && ram_ack) ? ramload : '0;
    assign dload  = ((r_state == DGRANT) && ram_ack) ? ramload : '0;
    assign halted = (r_state == HALTED);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        ramREN       = 1'b0;
        ramWEN       = 1'b0;
        ramaddr      = '0;
        ramstore     = '0;
        case (r_state)
            IDLE: begin
                if (halt)
                    w_next_state = HALTED;
                else if (w_dreq && iREN && (r_starve_cnt == SC_MAX))
                    w_next_state = IGRANT;
                else if (w_dreq)
                    w_next_state = DGRANT;
                else if (iREN)
                    w_next_state = IGRANT;
            end
            IGRANT: begin
                // A withdrawn request drops the strobes immediately and abandons the grant.
                if (!iREN) begin
                    w_next_state = IDLE;
                end else begin
                    ramREN  = 1'b1;
                    ramaddr = iaddr;
                    if (ram_ack)
                        w_next_state = halt ? HALTED : IDLE;
                end
            end
            DGRANT: begin
                if (!w_dreq) begin
                    w_next_state = IDLE;
                end else begin
                    ramaddr = daddr;
                    if (dWEN) begin
                        ramWEN   = 1'b1;
                        ramstore = dstore;
                    end else begin
                        ramREN   = 1'b1;
                    end
                    if (ram_ack)
                        w_next_state = halt ? HALTED : IDLE;
                end
            end
            HALTED: w_next_state = HALTED;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_starve_cnt <= '0;
        end else if (!iREN || w_idone) begin
            r_starve_cnt <= '0;
        end else if (w_ddone && (r_starve_cnt != SC_MAX)) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

`ifdef MEM_ARB_STATS_EN
    logic [CNT_W-1:0] r_icount;
    logic [CNT_W-1:0] r_dcount;
    logic [CNT_W-1:0] r_stall_count;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_icount      <= '0;
            r_dcount      <= '0;
            r_stall_count <= '0;
        end else begin
            if (w_idone && (r_icount != '1))
                r_icount <= r_icount + 1'b1;
            if (w_ddone && (r_dcount != '1))
                r_dcount <= r_dcount + 1'b1;
            if ((iwait || dwait) && (r_stall_count != '1))
                r_stall_count <= r_stall_count + 1'b1;
        end
    end

    assign icount      = r_icount;
    assign dcount      = r_dcount;
    assign stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        halt;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic        ram_ack;
    logic        halted;
`ifdef MEM_ARB_STATS_EN
    logic [15:0] icount;
    logic [15:0] dcount;
    logic [15:0] stall_count;
`endif

    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    mem_arbiter #(.WORD_W(32), .STARVE_MAX(4)) dut (
        .CLK(CLK), .nRST(nRST), .halt(halt),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ram_ack(ram_ack), .halted(halted)
`ifdef MEM_ARB_STATS_EN
        , .icount(icount), .dcount(dcount), .stall_count(stall_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        nRST = 1'b0; halt = 1'b0; iREN = 1'b0; iaddr = '0; dREN = 1'b0; dWEN = 1'b0;
        daddr = '0; dstore = '0; ramload = '0; ram_ack = 1'b0;
        #2;
        chk("rst_ramREN", 32'(ramREN), 32'h0);
        chk("rst_ramWEN", 32'(ramWEN), 32'h0);
        chk("rst_ramaddr", ramaddr, 32'h0);
        chk("rst_ramstore", ramstore, 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);
        chk("rst_starve", 32'(dut.r_starve_cnt), 32'd0);
        tick(); tick();
        nRST = 1'b1;

        tick(); iREN = 1'b1; iaddr = 32'h40; #2;
        chk("f_idle_ramREN", 32'(ramREN), 32'h0);
        chk("f_idle_iwait", 32'(iwait), 32'h1);
        tick(); #2;
        chk("f_grant_ramREN", 32'(ramREN), 32'h1);
        chk("f_grant_ramaddr", ramaddr, 32'h40);
        chk("f_grant_iwait", 32'(iwait), 32'h1);
        tick(); ram_ack = 1'b1; ramload = 32'h2408_0005; #2;
        chk("f_ack_iload", iload, 32'h2408_0005);
        chk("f_ack_iwait", 32'(iwait), 32'h0);
        tick(); ram_ack = 1'b0; iREN = 1'b0; #2;
        chk("f_after_ramREN", 32'(ramREN), 32'h0);
        chk("f_after_iwait", 32'(iwait), 32'h0);

        tick(); iREN = 1'b1; iaddr = 32'h44; dREN = 1'b1; daddr = 32'h100; #2;
        tick(); #2;
        chk("p_d_ramaddr", ramaddr, 32'h100);
        chk("p_d_ramREN", 32'(ramREN), 32'h1);
        chk("p_d_iwait", 32'(iwait), 32'h1);
        ram_ack = 1'b1; ramload = 32'h11; #1;
        chk("p_d_dload", dload, 32'h11);
        chk("p_d_dwait", 32'(dwait), 32'h0);
        chk("p_d_iwait_ack", 32'(iwait), 32'h1);
        tick(); dREN = 1'b0; ram_ack = 1'b0; #2;
        chk("p_idle_ramREN", 32'(ramREN), 32'h0);
        tick(); #2;
        chk("p_i_ramaddr", ramaddr, 32'h44);
        chk("p_i_ramREN", 32'(ramREN), 32'h1);
        ram_ack = 1'b1; #1;
        chk("p_i_iwait", 32'(iwait), 32'h0);
        tick(); ram_ack = 1'b0; iREN = 1'b0; #2;

        tick(); iREN = 1'b1; iaddr = 32'h48; dREN = 1'b1; daddr = 32'h300; #2;
        for (int k = 0; k < 4; k++) begin
            chk("s_idle_ramREN", 32'(ramREN), 32'h0);
            tick(); #2;
            chk("s_d_ramaddr", ramaddr, 32'h300);
            ram_ack = 1'b1;
            tick(); ram_ack = 1'b0; #2;
        end
        chk("s_cnt_sat", 32'(dut.r_starve_cnt), 32'd4);
        tick(); #2;
        chk("s_forced_ramaddr", ramaddr, 32'h48);
        chk("s_forced_dwait", 32'(dwait), 32'h1);
        ram_ack = 1'b1; #1;
        chk("s_forced_iwait", 32'(iwait), 32'h0);
        tick(); ram_ack = 1'b0; #2;
        chk("s_cnt_clr", 32'(dut.r_starve_cnt), 32'd0);
        tick(); #2;
        chk("s_resume_ramaddr", ramaddr, 32'h300);
        ram_ack = 1'b1;
        tick(); ram_ack = 1'b0; iREN = 1'b0; dREN = 1'b0; #2;

        tick(); dREN = 1'b1; dWEN = 1'b1; dstore = 32'hDEAD_BEEF; daddr = 32'h200; #2;
        tick(); #2;
        chk("w_ramWEN", 32'(ramWEN), 32'h1);
        chk("w_ramREN", 32'(ramREN), 32'h0);
        chk("w_ramstore", ramstore, 32'hDEAD_BEEF);
        chk("w_ramaddr", ramaddr, 32'h200);
        ram_ack = 1'b1;
        tick(); ram_ack = 1'b0; dREN = 1'b0; dWEN = 1'b0; #2;

        tick(); dREN = 1'b1; daddr = 32'h204; #2;
        tick(); halt = 1'b1; #2;
        chk("h_grant_ramREN", 32'(ramREN), 32'h1);
        chk("h_grant_halted", 32'(halted), 32'h0);
        tick(); ram_ack = 1'b1; ramload = 32'h55; #2;
        chk("h_ack_dload", dload, 32'h55);
        chk("h_ack_dwait", 32'(dwait), 32'h0);
        tick(); ram_ack = 1'b0; dREN = 1'b0; halt = 1'b0; #2;
        chk("h_halted", 32'(halted), 32'h1);
        tick(); iREN = 1'b1; iaddr = 32'h80; #2;
        chk("h_no_ramREN", 32'(ramREN), 32'h0);
        chk("h_iwait", 32'(iwait), 32'h1);
        tick(); ram_ack = 1'b1; #2;
        chk("h_ack_ignored_iwait", 32'(iwait), 32'h1);
        chk("h_still_halted", 32'(halted), 32'h1);
        tick(); ram_ack = 1'b0; iREN = 1'b0;

        nRST = 1'b0;
        tick(); nRST = 1'b1; iREN = 1'b1; iaddr = 32'h90; dWEN = 1'b1; daddr = 32'h208; dstore = 32'h1234; #2;
        tick(); #2;
        ram_ack = 1'b1;
        tick(); ram_ack = 1'b0; #2;
        tick(); #2;
        chk("r_pre_ramWEN", 32'(ramWEN), 32'h1);
        chk("r_pre_cnt", 32'(dut.r_starve_cnt), 32'd1);
        nRST = 1'b0; #1;
        chk("r_async_ramWEN", 32'(ramWEN), 32'h0);
        chk("r_async_ramaddr", ramaddr, 32'h0);
        chk("r_async_cnt", 32'(dut.r_starve_cnt), 32'd0);
        iREN = 1'b0; dWEN = 1'b0;
        tick(); nRST = 1'b1; #2;
        chk("r_post_halted", 32'(halted), 32'h0);
        chk("r_post_ramREN", 32'(ramREN), 32'h0);
        chk("r_post_state", 32'(dut.r_state), 32'(dut.IDLE));
`ifdef MEM_ARB_STATS_EN
        chk("r_post_icount", 32'(icount), 32'h0);
        chk("r_post_dcount", 32'(dcount), 32'h0);
        chk("r_post_stall", 32'(stall_count), 32'h0);
`endif
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
